// File: rtl/msrv32_load_store_unit_pkg.sv
// Shared types, funct3 codes and access-decode helpers for the load/store unit.
package msrv32_load_store_unit_pkg;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
      if (is_load) return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      return (f3 >= 3'b011);
   endfunction

   // f3[1:0] encodes access size for both loads and stores once illegal codes are gone
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_SB:   return 4'b0001 << off;
         F3_SH:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      case (f3)
         F3_SB:   return {4{rs2[7:0]}};
         F3_SH:   return {2{rs2[15:0]}};
         default: return rs2;
      endcase
   endfunction

endpackage

// File: rtl/msrv32_load_formatter.sv
// Combinational load-data lane select and sign/zero extension.
module msrv32_load_formatter
   import msrv32_load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  result = {24'd0, byte_sel};
         F3_LHU:  result = {16'd0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/msrv32_load_store_unit.sv
// Load/store stage: IDLE/ACCESS FSM issuing one word-aligned bus access per instruction,
// with request validation, wait-state timeout and formatted load return.
module msrv32_load_store_unit
   import msrv32_load_store_unit_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        valid_in,
   input  logic        load_in,
   input  logic        store_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   output logic        stall_out,
   output logic        dm_req_out,
   output logic        dm_wr_en_out,
   output logic [31:0] dm_addr_out,
   output logic [3:0]  dm_wr_mask_out,
   output logic [31:0] dm_wdata_out,
   input  logic        dm_hready_in,
   input  logic [31:0] dm_rdata_in,
   output logic [31:0] load_data_out,
   output logic        load_valid_out,
   output logic        store_done_out,
   output logic        misaligned_out,
   output logic        illegal_out,
   output logic        fault_out
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_t    state;
   logic [CW-1:0] wait_cnt;
   logic [1:0]    off_q;
   logic [2:0]    f3_q;
   logic [31:0]   fmt_data;
   logic          accept, is_load;

   assign accept     = (state == S_IDLE) && valid_in && (load_in || store_in);
   assign is_load    = load_in;
   assign stall_out  = (state == S_ACCESS);
   assign dm_req_out = (state == S_ACCESS);

   msrv32_load_formatter u_fmt (
      .rdata  (dm_rdata_in),
      .offset (off_q),
      .funct3 (f3_q),
      .result (fmt_data)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= S_IDLE;
         wait_cnt       <= '0;
         off_q          <= '0;
         f3_q           <= '0;
         dm_wr_en_out   <= 1'b0;
         dm_addr_out    <= '0;
         dm_wr_mask_out <= '0;
         dm_wdata_out   <= '0;
         load_data_out  <= '0;
         load_valid_out <= 1'b0;
         store_done_out <= 1'b0;
         misaligned_out <= 1'b0;
         illegal_out    <= 1'b0;
         fault_out      <= 1'b0;
      end else begin
         load_valid_out <= 1'b0;
         store_done_out <= 1'b0;
         misaligned_out <= 1'b0;
         illegal_out    <= 1'b0;
         fault_out      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (f3_illegal(is_load, funct3_in)) begin
                     illegal_out <= 1'b1;
                  end else if (f3_misaligned(funct3_in, iadder_in[1:0])) begin
                     misaligned_out <= 1'b1;
                  end else begin
                     off_q          <= iadder_in[1:0];
                     f3_q           <= funct3_in;
                     dm_wr_en_out   <= !is_load;
                     dm_addr_out    <= {iadder_in[31:2], 2'b00};
                     dm_wr_mask_out <= is_load ? 4'b0000 : store_mask(funct3_in, iadder_in[1:0]);
                     dm_wdata_out   <= is_load ? 32'd0 : store_wdata(funct3_in, rs2_in);
                     wait_cnt       <= '0;
                     state          <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               // hready on the last allowed cycle still completes normally
               if (dm_hready_in) begin
                  state <= S_IDLE;
                  if (dm_wr_en_out) begin
                     store_done_out <= 1'b1;
                  end else begin
                     load_data_out  <= fmt_data;
                     load_valid_out <= 1'b1;
                  end
               end else if (wait_cnt == CNT_LAST) begin
                  fault_out <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msrv32_load_store_unit.sv
// Randomized self-checking bench for msrv32_load_store_unit against a byte-level access model.
module tb_msrv32_load_store_unit;

   localparam int TIMEOUT = 16;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        valid_in = 1'b0, load_in = 1'b0, store_in = 1'b0;
   logic [2:0]  funct3_in = '0;
   logic [31:0] iadder_in = '0, rs2_in = '0;
   logic        stall_out, dm_req_out, dm_wr_en_out;
   logic [31:0] dm_addr_out, dm_wdata_out;
   logic [3:0]  dm_wr_mask_out;
   logic        dm_hready_in = 1'b0;
   logic [31:0] dm_rdata_in = '0;
   logic [31:0] load_data_out;
   logic        load_valid_out, store_done_out, misaligned_out, illegal_out, fault_out;

   int n_chk = 0, n_err = 0;
   logic [31:0] last_load = '0;

   msrv32_load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .load_in(load_in),
      .store_in(store_in), .funct3_in(funct3_in), .iadder_in(iadder_in), .rs2_in(rs2_in),
      .stall_out(stall_out), .dm_req_out(dm_req_out), .dm_wr_en_out(dm_wr_en_out),
      .dm_addr_out(dm_addr_out), .dm_wr_mask_out(dm_wr_mask_out), .dm_wdata_out(dm_wdata_out),
      .dm_hready_in(dm_hready_in), .dm_rdata_in(dm_rdata_in), .load_data_out(load_data_out),
      .load_valid_out(load_valid_out), .store_done_out(store_done_out),
      .misaligned_out(misaligned_out), .illegal_out(illegal_out), .fault_out(fault_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit m_illegal(input bit ld, input logic [2:0] f3);
      int v = int'(f3);
      return ld ? (v == 3 || v == 6 || v == 7) : (v >= 3);
   endfunction

   function automatic logic [3:0] m_mask(input logic [2:0] f3, input int off);
      logic [3:0] m = '0;
      for (int i = 0; i < 4; i++)
         if (i >= off && i < off + acc_size(f3)) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      case (acc_size(f3))
         1:       return (rs2 & 32'hFF) * 32'h01010101;
         2:       return (rs2 & 32'hFFFF) * 32'h00010001;
         default: return rs2;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
      int sz = acc_size(f3);
      logic [31:0] v = rd >> (8 * off);
      logic [31:0] lim;
      if (sz < 4) begin
         lim = (32'h1 << (8 * sz)) - 32'h1;
         v = v & lim;
         if (!f3[2] && v[8*sz-1]) v = v | ~lim;
      end
      return v;
   endfunction

   // Called just after a falling edge; returns just after a falling edge with the DUT idle.
   task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rd, input int waits);
      bit is_ld = ld;
      int off = int'(addr[1:0]);
      bit rej_ill, rej_mis, done;
      int c;
      valid_in = 1'b1; load_in = ld; store_in = st; funct3_in = f3;
      iadder_in = addr; rs2_in = rs2;
      @(posedge clk_in); @(negedge clk_in);
      valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
      iadder_in = $urandom; rs2_in = $urandom; funct3_in = 3'($urandom);
      if (!ld && !st) begin
         chk("noop_req", {31'd0, dm_req_out}, 32'd0);
         return;
      end
      rej_ill = m_illegal(is_ld, f3);
      rej_mis = !rej_ill && (off % acc_size(f3) != 0);
      if (rej_ill || rej_mis) begin
         chk("rej_illegal", {31'd0, illegal_out}, {31'd0, rej_ill});
         chk("rej_misalign", {31'd0, misaligned_out}, {31'd0, rej_mis});
         chk("rej_req", {31'd0, dm_req_out}, 32'd0);
         @(negedge clk_in);
         chk("rej_pulse_end", {30'd0, illegal_out, misaligned_out}, 32'd0);
         chk("rej_req2", {30'd0, dm_req_out, stall_out}, 32'd0);
         return;
      end
      c = 1; done = 0;
      while (!done) begin
         chk("acc_req_stall", {30'd0, dm_req_out, stall_out}, 32'd3);
         chk("acc_addr", dm_addr_out, addr & 32'hFFFF_FFFC);
         chk("acc_wr_en", {31'd0, dm_wr_en_out}, {31'd0, !is_ld});
         if (!is_ld) begin
            chk("acc_mask", {28'd0, dm_wr_mask_out}, {28'd0, m_mask(f3, off)});
            chk("acc_wdata", dm_wdata_out, m_wdata(f3, rs2));
         end
         chk("acc_quiet", {27'd0, load_valid_out, store_done_out, fault_out,
                           illegal_out, misaligned_out}, 32'd0);
         dm_hready_in = (c == waits + 1);
         dm_rdata_in  = dm_hready_in ? rd : $urandom;
         @(posedge clk_in); @(negedge clk_in);
         dm_hready_in = 1'b0; dm_rdata_in = $urandom;
         if (c == waits + 1) begin
            if (is_ld) last_load = m_load(f3, off, rd);
            chk("done_load_valid", {31'd0, load_valid_out}, {31'd0, is_ld});
            chk("done_store", {31'd0, store_done_out}, {31'd0, !is_ld});
            chk("done_fault", {31'd0, fault_out}, 32'd0);
            done = 1;
         end else if (c == TIMEOUT) begin
            chk("tmo_fault", {31'd0, fault_out}, 32'd1);
            chk("tmo_pulses", {30'd0, load_valid_out, store_done_out}, 32'd0);
            done = 1;
         end
         c++;
      end
      chk("end_idle", {30'd0, dm_req_out, stall_out}, 32'd0);
      chk("load_data", load_data_out, last_load);
   endtask

   initial begin
      #1;
      chk("rst_outs", {26'd0, stall_out, dm_req_out, load_valid_out, store_done_out,
                       misaligned_out, illegal_out}, 32'd0);
      chk("rst_bus", dm_addr_out | dm_wdata_out | load_data_out | {28'd0, dm_wr_mask_out}, 32'd0);
      @(negedge clk_in); @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);

      run_txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, '0, 0);
      run_txn(0, 1, 3'b000, 32'h103, 32'h000000A5, '0, 0);
      run_txn(1, 0, 3'b000, 32'h102, '0, 32'h0080FF00, 3);
      chk("lb_const", load_data_out, 32'hFFFFFF80);
      run_txn(1, 0, 3'b100, 32'h102, '0, 32'h0080FF00, 3);
      chk("lbu_const", load_data_out, 32'h00000080);
      run_txn(1, 0, 3'b001, 32'h101, '0, '0, 0);
      run_txn(1, 0, 3'b011, 32'h100, '0, '0, 0);
      run_txn(1, 0, 3'b010, 32'h200, '0, 32'h12345678, 1000);
      run_txn(1, 0, 3'b010, 32'h204, '0, 32'h12345678, TIMEOUT - 1);
      chk("lw_last_cycle", load_data_out, 32'h12345678);
      run_txn(1, 1, 3'b101, 32'h302, 32'hFFFFFFFF, 32'h8001_7FFE, 0);

      // reset during the second ACCESS cycle
      valid_in = 1'b1; load_in = 1'b1; funct3_in = 3'b010; iadder_in = 32'h400;
      @(posedge clk_in); @(negedge clk_in);
      valid_in = 1'b0; load_in = 1'b0;
      @(posedge clk_in); @(negedge clk_in);
      #1 rst_in = 1'b1;
      #1;
      chk("midrst_req_stall", {30'd0, dm_req_out, stall_out}, 32'd0);
      last_load = '0;
      @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("midrst_pulses", {27'd0, load_valid_out, store_done_out, fault_out,
                            illegal_out, misaligned_out}, 32'd0);
      run_txn(0, 1, 3'b010, 32'h500, 32'hCAFEF00D, '0, 0);

      for (int t = 0; t < 80; t++) begin
         int sel = int'($urandom_range(0, 9));
         bit ld = ($urandom_range(0, 1) == 1);
         bit st = !ld || (sel == 0);
         int w = (sel == 1) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1))
                            : int'($urandom_range(0, 3));
         logic [2:0] f3 = (sel < 8) ? 3'($urandom_range(0, 2)) | (ld ? {$urandom_range(0, 1) == 1, 2'b00} : 3'b000)
                                    : 3'($urandom);
         if (sel == 9 && t % 3 == 0) begin ld = 0; st = 0; end
         run_txn(ld, st, f3, $urandom, $urandom, $urandom, w);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
